// File: rtl/shallow_fifo_pkg.sv
// ---------------------------------------------------------------------------
// shallow_fifo_pkg
//   Shared types and constants for the FIFO burst reader slice.
//   - reader_state_t : burst reader FSM state (IDLE, BURST)
//   - SKID_DEPTH     : number of entries in the output buffer
// ---------------------------------------------------------------------------
package shallow_fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } reader_state_t;

    // The output buffer is two entries deep. That lets the reader keep
    // popping at one word per cycle while the consumer also takes one word
    // per cycle.
    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_burst_skid.sv
// ---------------------------------------------------------------------------
// fifo_burst_skid
//   Two-entry output buffer that holds {data, last} pairs in FIFO order.
//   The head entry drives the stream outputs.
//
//   Ports
//     clk, rst_n          : clock, asynchronous active-low reset
//     push                : write push_data/push_last this cycle
//     push_data/push_last : word and end-of-burst flag to store
//     m_valid/m_ready     : stream handshake (head entry valid / consumer ready)
//     m_data/m_last       : head entry
//     occupancy           : number of entries held (0..2)
//
//   Handshake: a word moves to the consumer on any rising edge where
//   m_valid && m_ready. m_valid never depends on m_ready. While
//   m_valid=1 && m_ready=0, m_data and m_last stay unchanged.
// ---------------------------------------------------------------------------
module fifo_burst_skid
    import shallow_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [1:0]            occupancy
);

    logic [DATA_WIDTH-1:0] head_data, head_data_next;
    logic [DATA_WIDTH-1:0] tail_data, tail_data_next;
    logic                  head_last, head_last_next;
    logic                  tail_last, tail_last_next;
    logic [1:0]            occ, occ_next;
    logic                  pop;

    localparam logic [1:0] FULL = 2'(SKID_DEPTH);

    assign m_valid   = (occ != 2'd0);
    assign pop       = m_valid & m_ready;
    assign m_data    = head_data;
    // Qualify with valid so a stale flag never lingers on an empty buffer.
    assign m_last    = head_last & m_valid;
    assign occupancy = occ;

    always_comb begin
        head_data_next = head_data;
        head_last_next = head_last;
        tail_data_next = tail_data;
        tail_last_next = tail_last;
        occ_next       = occ;

        case ({push, pop})
            2'b10: begin
                if (occ == 2'd0) begin
                    head_data_next = push_data;
                    head_last_next = push_last;
                    occ_next       = 2'd1;
                end else if (occ == 2'd1) begin
                    tail_data_next = push_data;
                    tail_last_next = push_last;
                    occ_next       = FULL;
                end
                // A push into a full buffer cannot happen: the reader only
                // pops from the FIFO when there is room here.
            end
            2'b01: begin
                if (occ == FULL) begin
                    head_data_next = tail_data;
                    head_last_next = tail_last;
                end
                occ_next = occ - 2'd1;
            end
            2'b11: begin
                // Pop and push in the same cycle, so occupancy does not change.
                // If the buffer is full, the tail moves up to the head and the
                // new word takes the tail slot, which keeps FIFO order.
                if (occ == FULL) begin
                    head_data_next = tail_data;
                    head_last_next = tail_last;
                    tail_data_next = push_data;
                    tail_last_next = push_last;
                end else begin
                    head_data_next = push_data;
                    head_last_next = push_last;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
            occ       <= 2'd0;
        end else begin
            head_data <= head_data_next;
            head_last <= head_last_next;
            tail_data <= tail_data_next;
            tail_last <= tail_last_next;
            occ       <= occ_next;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
//   Drains an upstream first-word-fall-through FIFO into a valid/ready
//   stream in bursts. A full burst of BURST_LEN words starts as soon as the
//   FIFO holds that many words. A smaller amount of data is flushed as a
//   partial burst after TIMEOUT cycles with no full burst available. The
//   last word of every burst carries m_last.
//
//   Ports
//     clk, rst_n        : clock, asynchronous active-low reset
//     fifo_rd_en        : pop request to the FIFO
//     fifo_rd_data      : FIFO head word (valid in the same cycle when not empty)
//     fifo_empty        : FIFO empty flag
//     fifo_count        : FIFO occupancy
//     m_valid/m_ready   : output stream handshake
//     m_data/m_last     : output stream word and end-of-burst marker
//     busy              : FSM in BURST, or words still buffered
//     partial           : single-cycle pulse in the cycle a timeout burst is launched
//
//   Stream handshake: a beat transfers on a rising edge with
//   m_valid && m_ready. m_valid does not wait for m_ready. Once m_valid is
//   raised, m_data and m_last hold until that beat transfers.
// ---------------------------------------------------------------------------
module fifo_burst_reader
    import shallow_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 32,
    parameter int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1,
    parameter int BURST_LEN   = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_empty,
    input  logic [COUNT_WIDTH-1:0] fifo_count,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_last,
    output logic                   busy,
    output logic                   partial
);

    // A burst can never be longer than the FIFO that feeds it.
    localparam int BURST_EFF = (BURST_LEN > FIFO_DEPTH) ? FIFO_DEPTH : BURST_LEN;
    localparam logic [COUNT_WIDTH-1:0] BURST_LEN_C = COUNT_WIDTH'(BURST_EFF);

    // The timer only has to reach TIMEOUT-1. That value is the flush point.
    localparam int TIMER_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = TIMER_WIDTH'(TIMEOUT - 1);

    reader_state_t          state, state_next;
    logic [TIMER_WIDTH-1:0] timer, timer_next;
    logic [COUNT_WIDTH-1:0] burst_len, burst_len_next;
    logic [COUNT_WIDTH-1:0] burst_cnt, burst_cnt_next;
    logic [1:0]             skid_occ;
    logic                   word_last;
    logic                   below_burst;

    // burst_cnt counts the words already popped in this burst. It stays
    // below burst_len, so cnt+1 fits in COUNT_WIDTH and never wraps.
    assign word_last   = ((burst_cnt + COUNT_WIDTH'(1)) == burst_len);
    assign below_burst = (fifo_count != '0) && (fifo_count < BURST_LEN_C);

    // Pop when there is a free slot, or when the consumer frees one in this
    // same cycle. This holds the buffer at most two words ahead of the
    // consumer and still gives one word per cycle.
    assign fifo_rd_en = (state == BURST) && !fifo_empty &&
                        ((skid_occ < 2'(SKID_DEPTH)) || (m_valid && m_ready));

    assign busy = (state != IDLE) || (skid_occ != 2'd0);

    always_comb begin
        state_next     = state;
        timer_next     = timer;
        burst_len_next = burst_len;
        burst_cnt_next = burst_cnt;
        partial        = 1'b0;

        case (state)
            IDLE: begin
                if (fifo_empty) begin
                    timer_next = '0;
                end else if (fifo_count >= BURST_LEN_C) begin
                    state_next     = BURST;
                    burst_len_next = BURST_LEN_C;
                    burst_cnt_next = '0;
                    timer_next     = '0;
                end else if (below_burst) begin
                    if (timer == TIMER_MAX) begin
                        // Flush what is there now. Words written later are
                        // left for the next burst.
                        state_next     = BURST;
                        burst_len_next = fifo_count;
                        burst_cnt_next = '0;
                        timer_next     = '0;
                        partial        = 1'b1;
                    end else begin
                        timer_next = timer + TIMER_WIDTH'(1);
                    end
                end
            end
            BURST: begin
                timer_next = '0;
                if (fifo_rd_en) begin
                    if (word_last) begin
                        state_next     = IDLE;
                        burst_cnt_next = '0;
                    end else begin
                        burst_cnt_next = burst_cnt + COUNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            burst_len <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            burst_len <= burst_len_next;
            burst_cnt <= burst_cnt_next;
        end
    end

    fifo_burst_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_rd_en),
        .push_data (fifo_rd_data),
        .push_last (word_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .occupancy (skid_occ)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int FD = 32;
    localparam int CW = $clog2(FD) + 1;
    localparam int BL = 8;
    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          partial;

    fifo_burst_reader #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (FD),
        .COUNT_WIDTH (CW),
        .BURST_LEN   (BL),
        .TIMEOUT     (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .busy         (busy),
        .partial      (partial)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model state
    logic [DW-1:0] fifo_q[$];     // upstream FIFO contents
    logic [DW:0]   exp_q[$];      // expected {last, data} beats
    int            errors;
    int            checks;
    int            cyc;

    // per-scenario observations
    int            scen_start;
    int            pops_done;
    int            beats_done;
    int            partial_cnt;
    int            partial_cyc;
    int            first_pop_cyc;
    int            first_beat_cyc;
    int            last_beat_cyc;
    int            max_ahead;
    logic          valid_after_pop;
    logic          pop_pending;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic clear_stats();
        scen_start      = cyc;
        pops_done       = 0;
        beats_done      = 0;
        partial_cnt     = 0;
        partial_cyc     = -1;
        first_pop_cyc   = -1;
        first_beat_cyc  = -1;
        last_beat_cyc   = -1;
        max_ahead       = 0;
        valid_after_pop = 1'b0;
        prev_stall      = 1'b0;
    endtask

    function automatic logic pick_ready(input int mode, input int scyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (scyc % 2) == 0;
        return 1'b1 & $urandom_range(0, 1);
    endfunction

    // One clock cycle. Entered on a falling edge: update the FIFO model,
    // drive inputs, sample outputs 1 ns later, then wait for the next
    // falling edge.
    task automatic step(input logic rdy, input logic do_push, input logic [DW-1:0] wdata,
                        input logic hide);
        logic [DW:0] exp_e;
        if (pop_pending) begin
            if (fifo_q.size() != 0) fifo_q.delete(0);
            pop_pending = 1'b0;
        end
        if (do_push) fifo_q.push_back(wdata);
        m_ready    = rdy;
        fifo_empty = hide || (fifo_q.size() == 0);
        fifo_count = hide ? '0 : CW'(fifo_q.size());
        if (fifo_q.size() != 0) fifo_rd_data = fifo_q[0];
        else fifo_rd_data = '0;
        #1;

        if (pops_done - beats_done > max_ahead) max_ahead = pops_done - beats_done;

        if (prev_stall) begin
            checks++;
            if (!(m_valid && m_data == prev_data && m_last == prev_last)) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got v=%0b d=%02h l=%0b want v=1 d=%02h l=%0b",
                         cyc, m_valid, m_data, m_last, prev_data, prev_last);
            end
        end

        if (m_valid) begin
            checks++;
            if (!busy) begin
                errors++;
                $display("FAIL busy_with_data cyc=%0d got busy=0 want 1", cyc);
            end
        end

        if (first_pop_cyc >= 0 && cyc == first_pop_cyc + 1) valid_after_pop = m_valid;

        if (m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat cyc=%0d got d=%02h l=%0b want no beat",
                         cyc, m_data, m_last);
            end else begin
                exp_e = exp_q.pop_front();
                if ({m_last, m_data} !== exp_e) begin
                    errors++;
                    $display("FAIL beat cyc=%0d got l=%0b d=%02h want l=%0b d=%02h",
                             cyc, m_last, m_data, exp_e[DW], exp_e[DW-1:0]);
                end
            end
            beats_done++;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
        end

        if (fifo_rd_en) begin
            checks++;
            if (fifo_empty) begin
                errors++;
                $display("FAIL pop_on_empty cyc=%0d got rd_en=1 want 0", cyc);
            end
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            pops_done++;
            pop_pending = 1'b1;
        end

        if (partial) begin
            partial_cnt++;
            partial_cyc = cyc;
        end

        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        cyc++;
        @(negedge clk);
    endtask

    // driver: push n words, one per cycle. A burst is closed every BL words
    // and by the final word.
    task automatic run_words(input int n, input int mode, input logic seq);
        logic [DW-1:0] d;
        logic          l;
        for (int i = 0; i < n; i++) begin
            d = seq ? DW'(i + 1) : DW'($urandom_range(0, 255));
            l = (((i + 1) % BL) == 0) || (i == n - 1);
            exp_q.push_back({l, d});
            step(pick_ready(mode, cyc - scen_start), 1'b1, d, 1'b0);
        end
    endtask

    task automatic drain(input int mode);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && k < 300) begin
            step(pick_ready(mode, cyc - scen_start), 1'b0, '0, 1'b0);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d beats outstanding want 0", exp_q.size());
            exp_q.delete();
        end
        for (int j = 0; j < 24; j++) step(pick_ready(mode, cyc - scen_start), 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        m_ready      = 1'b0;
        fifo_empty   = 1'b1;
        fifo_count   = '0;
        fifo_rd_data = '0;
        pop_pending  = 1'b0;
        #12;
        checks++;
        if ({m_valid, m_last, m_data, busy, partial, fifo_rd_en} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b l=%0b d=%02h busy=%0b p=%0b rd=%0b want all 0",
                     m_valid, m_last, m_data, busy, partial, fifo_rd_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if ({m_valid, busy, partial, fifo_rd_en} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset got v=%0b busy=%0b p=%0b rd=%0b want 0",
                     m_valid, busy, partial, fifo_rd_en);
        end
    endtask

    task automatic test_full_burst();
        clear_stats();
        run_words(8, 0, 1'b1);
        drain(0);
        checks++;
        if (beats_done != 8 || last_beat_cyc - first_beat_cyc != 7) begin
            errors++;
            $display("FAIL full_burst_rate got beats=%0d span=%0d want beats=8 span=7",
                     beats_done, last_beat_cyc - first_beat_cyc);
        end
        checks++;
        if (valid_after_pop !== 1'b1) begin
            errors++;
            $display("FAIL first_latency got m_valid=%0b one cycle after first pop want 1",
                     valid_after_pop);
        end
        checks++;
        if (partial_cnt != 0) begin
            errors++;
            $display("FAIL full_burst_partial got %0d pulses want 0", partial_cnt);
        end
    endtask

    task automatic test_partial_timeout();
        clear_stats();
        run_words(3, 0, 1'b0);
        drain(0);
        checks++;
        if (partial_cnt != 1 || partial_cyc - scen_start != TO - 1) begin
            errors++;
            $display("FAIL partial_timing got pulses=%0d at offset %0d want 1 at %0d",
                     partial_cnt, partial_cyc - scen_start, TO - 1);
        end
        checks++;
        if (beats_done != 3) begin
            errors++;
            $display("FAIL partial_beats got %0d want 3", beats_done);
        end
    endtask

    task automatic test_backpressure();
        clear_stats();
        run_words(8, 1, 1'b0);
        drain(1);
        checks++;
        if (max_ahead > 2) begin
            errors++;
            $display("FAIL pops_ahead got %0d want <=2", max_ahead);
        end
        checks++;
        if (beats_done != 8 || partial_cnt != 0) begin
            errors++;
            $display("FAIL backpressure_beats got beats=%0d partial=%0d want 8 and 0",
                     beats_done, partial_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        run_words(20, 0, 1'b0);
        drain(0);
        checks++;
        if (beats_done != 20 || partial_cnt != 1) begin
            errors++;
            $display("FAIL back_to_back got beats=%0d partial=%0d want 20 and 1",
                     beats_done, partial_cnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        int k;
        clear_stats();
        run_words(8, 0, 1'b1);
        k = 0;
        while (beats_done < 4 && k < 40) begin
            step(1'b1, 1'b0, '0, 1'b0);
            k++;
        end
        checks++;
        if (beats_done != 4) begin
            errors++;
            $display("FAIL reach_fourth_beat got %0d beats want 4", beats_done);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_last, m_data, busy, partial, fifo_rd_en} !== '0) begin
            errors++;
            $display("FAIL async_reset got v=%0b l=%0b d=%02h busy=%0b p=%0b rd=%0b want all 0",
                     m_valid, m_last, m_data, busy, partial, fifo_rd_en);
        end
        // The upstream FIFO shares this reset, so the model is flushed too.
        fifo_q.delete();
        exp_q.delete();
        pop_pending = 1'b0;
        prev_stall  = 1'b0;
        fifo_empty  = 1'b1;
        fifo_count  = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (beats_done != 4 || busy !== 1'b0 || partial_cnt != 0) begin
            errors++;
            $display("FAIL after_reset got beats=%0d busy=%0b partial=%0d want 4 0 0",
                     beats_done, busy, partial_cnt);
        end
    endtask

    task automatic test_timer_restart();
        logic [DW-1:0] d[4];
        int            hide_cyc;
        clear_stats();
        for (int i = 0; i < 4; i++) begin
            d[i] = DW'($urandom_range(0, 255));
            exp_q.push_back({(i == 3), d[i]});
        end
        step(1'b1, 1'b1, d[0], 1'b0);
        step(1'b1, 1'b1, d[1], 1'b0);
        hide_cyc = cyc;
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, d[2], 1'b0);
        step(1'b1, 1'b1, d[3], 1'b0);
        drain(0);
        checks++;
        if (partial_cnt != 1 || partial_cyc - hide_cyc != TO) begin
            errors++;
            $display("FAIL timer_restart got pulses=%0d at offset %0d want 1 at %0d",
                     partial_cnt, partial_cyc - hide_cyc, TO);
        end
        checks++;
        if (beats_done != 4) begin
            errors++;
            $display("FAIL timer_restart_beats got %0d want 4", beats_done);
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 4; it++) begin
            clear_stats();
            n = $urandom_range(1, 30);
            run_words(n, 2, 1'b0);
            drain(2);
            checks++;
            if (beats_done != n || partial_cnt != ((n % BL) != 0 ? 1 : 0) || max_ahead > 2) begin
                errors++;
                $display("FAIL random n=%0d got beats=%0d partial=%0d ahead=%0d want %0d %0d <=2",
                         n, beats_done, partial_cnt, max_ahead, n, ((n % BL) != 0 ? 1 : 0));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        clear_stats();
        test_reset();
        test_full_burst();
        test_partial_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_burst();
        test_timer_restart();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning word width, equal to the FIFO's width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 32, meaning depth of the upstream FIFO.
REQ-003 The block SHALL have parameter COUNT_WIDTH, default $clog2(FIFO_DEPTH)+1, meaning width of the FIFO occupancy count.
REQ-004 The block SHALL have parameter BURST_LEN, default 8, meaning full-burst word count; legal range 1..FIFO_DEPTH.
REQ-005 The block SHALL have parameter TIMEOUT, default 16, meaning idle cycles before a partial burst is flushed; must be at least 1.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port fifo_rd_en, output, 1 bit: pop request to the FIFO.
REQ-009 The block SHALL have port fifo_rd_data, input, DATA_WIDTH bits: FIFO head word, valid in the same cycle whenever fifo_empty=0 (asynchronous distributed-RAM read).
REQ-010 The block SHALL have port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-011 The block SHALL have port fifo_count, input, COUNT_WIDTH bits: FIFO occupancy.
REQ-012 The block SHALL have port m_valid, output, 1 bit: stream word valid.
REQ-013 The block SHALL have port m_ready, input, 1 bit: stream consumer ready.
REQ-014 The block SHALL have port m_data, output, DATA_WIDTH bits: stream word.
REQ-015 The block SHALL have port m_last, output, 1 bit: marks the final word of a burst.
REQ-016 The block SHALL have port busy, output, 1 bit: high when the FSM is not IDLE or the output buffer holds data.
REQ-017 The block SHALL have port partial, output, 1 bit: one-cycle pulse when a timeout (partial) burst starts.

Function
REQ-018 The FSM SHALL have states IDLE and BURST.
REQ-019 In IDLE, when fifo_count>=BURST_LEN, the FSM SHALL go to BURST next cycle with burst length = BURST_LEN.
REQ-020 In IDLE, while fifo_count is between 1 and BURST_LEN-1, the block SHALL increment an idle timer each cycle; fifo_empty=1 SHALL clear the timer.
REQ-021 When the timer equals TIMEOUT-1 and fifo_count<BURST_LEN, the FSM SHALL go to BURST with burst length = fifo_count sampled that cycle, and SHALL assert partial for that one cycle.
REQ-022 On entry to BURST the timer SHALL be cleared.
REQ-023 fifo_rd_en SHALL equal (state==BURST) AND NOT fifo_empty AND (buffer occupancy<2 OR (m_valid AND m_ready)); a pop occurs only when fifo_rd_en=1.
REQ-024 Each popped word SHALL be written into the output buffer in the same cycle, with its last flag set if it is word number burst length of the burst.
REQ-025 After the pop that carries last, the FSM SHALL return to IDLE in the next cycle.
REQ-026 A new burst MAY begin while earlier words remain buffered; the per-entry last flags SHALL keep bursts separated.
REQ-027 The output buffer SHALL hold 2 entries in FIFO order; m_valid SHALL be high whenever occupancy is greater than 0; m_data and m_last SHALL come from the head entry.
REQ-028 A transfer occurs on m_valid AND m_ready; while m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
REQ-029 A simultaneous push and pop on a full buffer SHALL leave occupancy at 2 with correct ordering.
REQ-030 Latency from the first pop to m_valid SHALL be 1 cycle.
REQ-031 Sustained throughput with m_ready=1 SHALL be 1 word per cycle.
REQ-032 The burst word counter SHALL be COUNT_WIDTH bits wide and SHALL not wrap within a burst.

Reset
REQ-033 rst_n=0 SHALL asynchronously force: state=IDLE, timer=0, burst counter=0, buffer occupancy=0, m_valid=0, m_last=0, m_data=0, partial=0, busy=0, fifo_rd_en=0.
REQ-034 Reset asserted mid-burst SHALL discard all buffered words, with no m_last emitted.
REQ-035 Reset release SHALL be synchronous to clk; the first transition out of IDLE SHALL occur no earlier than the first clk edge after release.

Structure
REQ-036 Package shallow_fifo_pkg SHALL hold typedef reader_state_t (IDLE, BURST).
REQ-037 Sub-module fifo_burst_skid SHALL implement the 2-entry data+last buffer with valid/ready, parameterised by DATA_WIDTH.

Verification
REQ-038 Scenario 1: write 8 words 0x01..0x08, hold m_ready=1 -> 8 consecutive m_valid beats 0x01..0x08, m_last on 0x08, partial=0.
REQ-039 Scenario 2: write 3 words and stop -> after 16 idle cycles partial pulses; 3 beats follow with m_last on the 3rd.
REQ-040 Scenario 3: 8 words with m_ready toggling 1,0,1,0 -> order preserved, data stable while stalled, at most 2 pops ahead of the consumer.
REQ-041 Scenario 4: write 20 words, m_ready=1 -> two full bursts (m_last on words 8 and 16), then a 4-word partial burst after the timeout.
REQ-042 Scenario 5: assert rst_n=0 after the 4th beat of a burst -> all outputs reach their reset values immediately; no further beats.
REQ-043 Scenario 6: 2 words, empty for 1 cycle, then 2 more -> the timer restarts; one partial burst of 4 words follows.
